mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LINE_BITS, 256, cache line width on both cache ports.
REQ-002 Parameter: BEAT_BITS, 64, burst-memory beat width; the burst length is LINE_BITS/BEAT_BITS (4).
REQ-003 The port list SHALL be:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  icache line-fill request
- i_addr  in  32  icache line address
- i_rdata  out  LINE_BITS  fill data to icache
- i_resp  out  1  icache completion pulse
- d_read  in  1  dcache line-fill request
- d_write  in  1  dcache writeback request
- d_addr  in  32  dcache line address
- d_wdata  in  LINE_BITS  dcache writeback line
- d_rdata  out  LINE_BITS  fill data to dcache
- d_resp  out  1  dcache completion pulse
- mem_read  out  1  burst read request
- mem_write  out  1  burst write request
- mem_addr  out  32  burst base address
- mem_wdata  out  BEAT_BITS  current write beat
- mem_rdata  in  BEAT_BITS  current read beat
- mem_resp  in  1  beat accepted/valid

Function
REQ-004 The FSM SHALL have the states IDLE, I_RD, D_RD, D_WR and DONE.
REQ-005 In IDLE with any request asserted, the arbiter SHALL select one owner and enter the matching service state on the next edge; the owner is latched until DONE.
REQ-006 With the default policy, a dcache request SHALL win over an icache request.
REQ-007 In a service state, mem_read (I_RD, D_RD) or mem_write (D_WR) SHALL be asserted combinationally from the state and held until the final beat.
REQ-008 mem_addr SHALL be the owner's address with bits [4:0] forced to zero.
REQ-009 A 2-bit beat counter SHALL advance on each cycle in which mem_resp is high.
- Read: mem_rdata is stored into line slice [cnt].
- Write: mem_wdata = d_wdata slice [cnt].
- Beat 0 is the least-significant slice.
REQ-010 On mem_resp with cnt==3, the FSM SHALL enter DONE, deassert mem_read/mem_write, and clear cnt.
REQ-011 In DONE, the arbiter SHALL assert the owner's resp for exactly one cycle, with i_rdata/d_rdata holding the assembled line, then return to IDLE.
REQ-012 Requests SHALL be ignored while in DONE.
REQ-013 A client request re-presented in the IDLE cycle after DONE SHALL be treated as new.
REQ-014 A non-owner's resp SHALL remain 0 at all times.
REQ-015 Both rdata outputs SHALL drive the shared line buffer; consumers sample only on resp.
REQ-016 d_read and d_write asserted together is illegal; d_write SHALL take priority and a simulation assertion SHALL flag the condition.
REQ-017 Request deassertion mid-burst SHALL NOT abort the burst; it completes, and the resp is still pulsed.
REQ-018 Minimum read latency, from request to resp, SHALL be 6 cycles: 1 arbitration cycle, 4 beats, 1 DONE cycle.

Reset
REQ-019 On rst, the arbiter SHALL enter IDLE, clear cnt, line buffer and owner, and drive all outputs to 0 on the following cycle.
REQ-020 rst mid-burst SHALL abandon the burst with no resp pulsed.

Configuration
REQ-021 With ARB_RR_EN defined, arbitration SHALL be round-robin: on contention, the client not served last wins; the last-served flag resets to icache, so dcache wins the first tie.
REQ-022 Without ARB_RR_EN, arbitration SHALL be fixed dcache priority per REQ-006.

Structure
REQ-023 The arb_state_t enum, LINE_BITS/BEAT_BITS defaults and the owner encoding SHALL reside in the shared package mem_arb_pkg.
REQ-024 The beat counter, line assembly and slice selection SHALL be one sub-module, line_burst_adapter; the arbitration FSM SHALL remain in mem_arbiter.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- icache fill: i_read, i_addr=0x0000_1064, beats 0x11..,0x22..,0x33..,0x44.. → mem_addr=0x0000_1060; i_rdata={0x44..,0x33..,0x22..,0x11..}; i_resp one cycle at request+6.
- dcache writeback: d_write, d_addr=0x8000_0020, d_wdata=0xDDDD..CCCC..BBBB..AAAA.. → mem_wdata beats AAAA, BBBB, CCCC, DDDD in order; d_resp once; i_resp stays 0.
- contention: i_read and d_read in the same cycle, default build → dcache served first; icache served in the next IDLE window.
- contention with ARB_RR_EN: three back-to-back simultaneous requests → owners d, i, d.
- stalled memory: mem_resp gaps of 3 cycles between beats → data assembled correctly; mem_read held continuously.
- reset after beat 2 → outputs zero the next cycle; no resp; a new i_read completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-client cache-to-burst-memory arbiter.
// Holds the FSM state encoding, the owner encoding and line address helpers.
package mem_arb_pkg;

  localparam int LINE_BITS_DEF = 256;
  localparam int BEAT_BITS_DEF = 64;

  // Line addresses are 32-byte aligned for the default line size.
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return addr & LINE_MASK;
  endfunction

endpackage

// File: rtl/line_burst_adapter.sv
// Converts between a full cache line and a burst of memory beats: beat counter,
// read-line assembly and write-beat selection. Beat 0 is the least-significant slice.
module line_burst_adapter
  import mem_arb_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int BEAT_BITS = BEAT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_ren,
  input  logic                 i_wen,
  input  logic                 i_mem_resp,
  input  logic [BEAT_BITS-1:0] i_mem_rdata,
  input  logic [LINE_BITS-1:0] i_wline,
  output logic                 o_last,
  output logic [BEAT_BITS-1:0] o_wbeat,
  output logic [LINE_BITS-1:0] o_line
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]     r_cnt;
  logic                 w_adv;
  logic [BEAT_BITS-1:0] w_wbeats [BEATS];

  assign w_adv  = (i_ren | i_wen) & i_mem_resp;
  assign o_last = w_adv && (r_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_adv) begin
      r_cnt <= o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
    logic [BEAT_BITS-1:0] r_beat;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_beat <= '0;
      end else if (i_ren && i_mem_resp && (r_cnt == CNT_W'(gi))) begin
        r_beat <= i_mem_rdata;
      end
    end

    assign o_line[gi*BEAT_BITS +: BEAT_BITS] = r_beat;
    assign w_wbeats[gi] = i_wline[gi*BEAT_BITS +: BEAT_BITS];
  end

  assign o_wbeat = i_wen ? w_wbeats[r_cnt] : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one burst memory port.
// Define ARB_RR_EN for round-robin arbitration; default is fixed dcache priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int BEAT_BITS = BEAT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [31:0]          i_addr,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [31:0]          d_addr,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_addr,
  output logic [BEAT_BITS-1:0] mem_wdata,
  input  logic [BEAT_BITS-1:0] mem_rdata,
  input  logic                 mem_resp
);

  arb_state_t     r_state;
  owner_t         r_owner;
  logic [31:0]    r_addr;
  logic           r_i_resp;
  logic           r_d_resp;
`ifdef ARB_RR_EN
  logic           r_last_d;
`endif

  logic           w_i_req;
  logic           w_d_req;
  logic           w_pick_d;
  logic           w_ren;
  logic           w_wen;
  logic           w_last;
  logic [LINE_BITS-1:0] w_line;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  always_comb begin
    w_pick_d = w_d_req;
`ifdef ARB_RR_EN
    // On a tie the client that was not granted last time wins.
    w_pick_d = w_d_req && (!w_i_req || !r_last_d);
`endif
  end

  assign w_ren = (r_state == I_RD) || (r_state == D_RD);
  assign w_wen = (r_state == D_WR);

  line_burst_adapter #(
    .LINE_BITS (LINE_BITS),
    .BEAT_BITS (BEAT_BITS)
  ) u_adapter (
    .clk         (clk),
    .rst         (rst),
    .i_ren       (w_ren),
    .i_wen       (w_wen),
    .i_mem_resp  (mem_resp),
    .i_mem_rdata (mem_rdata),
    .i_wline     (d_wdata),
    .o_last      (w_last),
    .o_wbeat     (mem_wdata),
    .o_line      (w_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= OWN_NONE;
      r_addr   <= '0;
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
`ifdef ARB_RR_EN
      r_last_d <= 1'b0;
`endif
    end else begin
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_owner <= OWN_D;
            r_addr  <= line_base(d_addr);
            r_state <= d_write ? D_WR : D_RD;
`ifdef ARB_RR_EN
            r_last_d <= 1'b1;
`endif
          end else if (w_i_req) begin
            r_owner <= OWN_I;
            r_addr  <= line_base(i_addr);
            r_state <= I_RD;
`ifdef ARB_RR_EN
            r_last_d <= 1'b0;
`endif
          end
        end
        I_RD, D_RD, D_WR: begin
          // The burst always runs to completion once granted.
          if (w_last) begin
            r_state  <= DONE;
            r_i_resp <= (r_owner == OWN_I);
            r_d_resp <= (r_owner == OWN_D);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_owner <= OWN_NONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_read  = w_ren;
  assign mem_write = w_wen;
  assign mem_addr  = r_addr;
  assign i_resp    = r_i_resp;
  assign d_resp    = r_d_resp;
  assign i_rdata   = w_line;
  assign d_rdata   = w_line;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fills, writeback, contention, stalls, reset mid-burst.
// A negedge memory model answers bursts; expected values are hand-written constants.
module tb_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int errors = 0;
  int checks = 0;

  // memory model state
  logic [63:0] tbl  [4];
  logic [63:0] wcap [4];
  logic [31:0] addr_cap;
  int          gap = 0;
  int          idx = 0;
  int          wait_cnt = 0;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Burst memory: waits `gap` cycles before every beat, then presents one beat.
  always @(negedge clk) begin
    if (rst || !(mem_read || mem_write)) begin
      mem_resp  = 1'b0;
      mem_rdata = '0;
      idx       = 0;
      wait_cnt  = gap;
    end else if (idx >= 4) begin
      mem_resp = 1'b0;
    end else if (wait_cnt > 0) begin
      mem_resp = 1'b0;
      wait_cnt = wait_cnt - 1;
    end else begin
      mem_resp  = 1'b1;
      mem_rdata = tbl[idx];
      wcap[idx] = mem_wdata;
      addr_cap  = mem_addr;
      idx       = idx + 1;
      wait_cnt  = gap;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_resp(input int limit, output int cyc, output logic gi, output logic gd);
    cyc = 0;
    while (cyc < limit && !i_resp && !d_resp) begin
      @(negedge clk);
      cyc++;
    end
    gi = i_resp;
    gd = d_resp;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 64'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if ({i_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL reset_resp: got %b want 00", {i_resp, d_resp}); end
    checks++; if (i_rdata !== 256'h0) begin errors++; $display("FAIL reset_i_rdata: got %h want 0", i_rdata); end
    checks++; if (d_rdata !== 256'h0) begin errors++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL idle_no_req: mem_read got %b want 0", mem_read); end
    $display("txn reset done");
  endtask

  task automatic test_icache_fill;
    int   cyc;
    logic gi, gd;
    tbl[0] = 64'h1111_1111_1111_1111; tbl[1] = 64'h2222_2222_2222_2222;
    tbl[2] = 64'h3333_3333_3333_3333; tbl[3] = 64'h4444_4444_4444_4444;
    i_addr = 32'h0000_1064;
    i_read = 1'b1;
    wait_resp(40, cyc, gi, gd);
    i_read = 1'b0;
    $display("txn icache_fill addr=%h cycles=%0d", addr_cap, cyc);
    // request cycle is cycle 1, so resp shows in cycle 6: five edges after the request
    checks++; if (cyc !== 5) begin errors++; $display("FAIL fill_latency: got %0d want 5", cyc); end
    checks++; if ({gi, gd} !== 2'b10) begin errors++; $display("FAIL fill_resp: got i/d=%b want 10", {gi, gd}); end
    checks++; if (addr_cap !== 32'h0000_1060) begin errors++; $display("FAIL fill_addr: got %h want 00001060", addr_cap); end
    checks++;
    if (i_rdata !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
      errors++; $display("FAIL fill_data: got %h", i_rdata);
    end
    @(negedge clk);
    checks++; if (i_resp !== 1'b0) begin errors++; $display("FAIL fill_resp_width: got %b want 0", i_resp); end
  endtask

  task automatic test_dcache_writeback;
    int   cyc;
    int   d_pulses;
    logic i_seen;
    d_addr  = 32'h8000_0020;
    d_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    d_write = 1'b1;
    cyc = 0; i_seen = 1'b0;
    while (cyc < 40 && !d_resp) begin
      if (i_resp) i_seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    d_write = 1'b0;
    $display("txn dcache_writeback addr=%h cycles=%0d", addr_cap, cyc);
    checks++; if (d_resp !== 1'b1) begin errors++; $display("FAIL wb_resp: got %b want 1", d_resp); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL wb_latency: got %0d want 5", cyc); end
    checks++; if (addr_cap !== 32'h8000_0020) begin errors++; $display("FAIL wb_addr: got %h want 80000020", addr_cap); end
    checks++; if (wcap[0] !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL wb_beat0: got %h want AAAA..", wcap[0]); end
    checks++; if (wcap[1] !== 64'hBBBB_BBBB_BBBB_BBBB) begin errors++; $display("FAIL wb_beat1: got %h want BBBB..", wcap[1]); end
    checks++; if (wcap[2] !== 64'hCCCC_CCCC_CCCC_CCCC) begin errors++; $display("FAIL wb_beat2: got %h want CCCC..", wcap[2]); end
    checks++; if (wcap[3] !== 64'hDDDD_DDDD_DDDD_DDDD) begin errors++; $display("FAIL wb_beat3: got %h want DDDD..", wcap[3]); end
    d_pulses = 0;
    repeat (4) begin
      if (i_resp) i_seen = 1'b1;
      @(negedge clk);
      if (d_resp) d_pulses++;
    end
    checks++; if (d_pulses !== 0) begin errors++; $display("FAIL wb_resp_once: extra pulses got %0d want 0", d_pulses); end
    checks++; if (i_seen !== 1'b0) begin errors++; $display("FAIL wb_i_resp: got %b want 0", i_seen); end
  endtask

  task automatic test_contention;
    int   cyc;
    logic gi, gd;
    tbl[0] = 64'h5555_5555_5555_5555; tbl[1] = 64'h6666_6666_6666_6666;
    tbl[2] = 64'h7777_7777_7777_7777; tbl[3] = 64'h8888_8888_8888_8888;
    i_addr = 32'h0000_2000;
    d_addr = 32'h0000_3008;
    i_read = 1'b1;
    d_read = 1'b1;
    wait_resp(40, cyc, gi, gd);
    d_read = 1'b0;
    $display("txn contention_first i=%b d=%b cycles=%0d", gi, gd, cyc);
    checks++; if ({gi, gd} !== 2'b01) begin errors++; $display("FAIL cont_first_owner: got i/d=%b want 01", {gi, gd}); end
    checks++; if (addr_cap !== 32'h0000_3000) begin errors++; $display("FAIL cont_first_addr: got %h want 00003000", addr_cap); end
    checks++;
    if (d_rdata !== {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777, 64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555}) begin
      errors++; $display("FAIL cont_d_data: got %h", d_rdata);
    end
    tbl[0] = 64'h9999_9999_9999_9999; tbl[1] = 64'h0123_4567_89AB_CDEF;
    tbl[2] = 64'hFEDC_BA98_7654_3210; tbl[3] = 64'h1357_9BDF_2468_ACE0;
    @(negedge clk);
    wait_resp(40, cyc, gi, gd);
    i_read = 1'b0;
    $display("txn contention_second i=%b d=%b cycles=%0d", gi, gd, cyc);
    checks++; if ({gi, gd} !== 2'b10) begin errors++; $display("FAIL cont_second_owner: got i/d=%b want 10", {gi, gd}); end
    checks++; if (cyc !== 5) begin errors++; $display("FAIL cont_second_latency: got %0d want 5", cyc); end
    checks++; if (addr_cap !== 32'h0000_2000) begin errors++; $display("FAIL cont_second_addr: got %h want 00002000", addr_cap); end
    checks++;
    if (i_rdata !== {64'h1357_9BDF_2468_ACE0, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 64'h9999_9999_9999_9999}) begin
      errors++; $display("FAIL cont_i_data: got %h", i_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int         cyc;
    logic       gi, gd;
    logic [2:0] got_d;
    logic [2:0] exp_d;
`ifdef ARB_RR_EN
    exp_d = 3'b101;   // owners d, i, d
`else
    exp_d = 3'b111;   // fixed priority: d, d, d
`endif
    got_d = 3'b000;
    i_addr = 32'h0000_5000;
    d_addr = 32'h0000_6000;
    i_read = 1'b1;
    d_read = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      wait_resp(40, cyc, gi, gd);
      got_d[k] = gd;
      $display("txn back_to_back round=%0d i=%b d=%b cycles=%0d", k, gi, gd, cyc);
      checks++; if ((gi ^ gd) !== 1'b1) begin errors++; $display("FAIL b2b_one_resp: round %0d got i/d=%b want exactly one", k, {gi, gd}); end
    end
    i_read = 1'b0;
    d_read = 1'b0;
    checks++; if (got_d !== exp_d) begin errors++; $display("FAIL b2b_owners: got d-mask %b want %b", got_d, exp_d); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL b2b_idle: mem_read got %b want 0", mem_read); end
  endtask

  task automatic test_stalled;
    int   cyc;
    logic drop;
    gap = 3;
    tbl[0] = 64'hA1A1_A1A1_A1A1_A1A1; tbl[1] = 64'hB2B2_B2B2_B2B2_B2B2;
    tbl[2] = 64'hC3C3_C3C3_C3C3_C3C3; tbl[3] = 64'hD4D4_D4D4_D4D4_D4D4;
    @(negedge clk);
    i_addr = 32'h0000_7000;
    i_read = 1'b1;
    cyc = 0; drop = 1'b0;
    while (cyc < 60 && !i_resp) begin
      @(negedge clk);
      cyc++;
      if (!i_resp && !mem_read) drop = 1'b1;
    end
    i_read = 1'b0;
    $display("txn stalled_fill cycles=%0d", cyc);
    // 1 arbitration + 4 x (3 wait + 1 beat) = 17 edges to resp
    checks++; if (cyc !== 17) begin errors++; $display("FAIL stall_latency: got %0d want 17", cyc); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL stall_mem_read_held: dropped=%b want 0", drop); end
    checks++;
    if (i_rdata !== {64'hD4D4_D4D4_D4D4_D4D4, 64'hC3C3_C3C3_C3C3_C3C3, 64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1A1}) begin
      errors++; $display("FAIL stall_data: got %h", i_rdata);
    end
    gap = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst;
    int   cyc;
    int   pulses;
    logic gi, gd;
    tbl[0] = 64'h0F0F_0F0F_0F0F_0F0F; tbl[1] = 64'h1E1E_1E1E_1E1E_1E1E;
    tbl[2] = 64'h2D2D_2D2D_2D2D_2D2D; tbl[3] = 64'h3C3C_3C3C_3C3C_3C3C;
    i_addr = 32'h0000_9020;
    i_read = 1'b1;
    repeat (4) @(negedge clk);   // beats 0..2 accepted
    rst    = 1'b1;
    i_read = 1'b0;
    @(negedge clk);
    checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL rstmid_mem_req: got %b want 00", {mem_read, mem_write}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_mem_addr: got %h want 0", mem_addr); end
    checks++; if (i_rdata !== 256'h0) begin errors++; $display("FAIL rstmid_i_rdata: got %h want 0", i_rdata); end
    checks++; if ({i_resp, d_resp} !== 2'b00) begin errors++; $display("FAIL rstmid_resp: got %b want 00", {i_resp, d_resp}); end
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (i_resp || d_resp) pulses++;
    end
    $display("txn reset_mid_burst stray_resps=%0d", pulses);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_resp: got %0d pulses want 0", pulses); end
    tbl[0] = 64'h0101_0101_0101_0101; tbl[1] = 64'h0202_0202_0202_0202;
    tbl[2] = 64'h0303_0303_0303_0303; tbl[3] = 64'h0404_0404_0404_0404;
    i_addr = 32'h0000_4044;
    i_read = 1'b1;
    wait_resp(40, cyc, gi, gd);
    i_read = 1'b0;
    $display("txn post_reset_fill i=%b cycles=%0d", gi, cyc);
    checks++; if ({gi, gd} !== 2'b10 || cyc !== 5) begin errors++; $display("FAIL rstmid_refill: got i/d=%b cycles=%0d want 10 cycles=5", {gi, gd}, cyc); end
    checks++; if (addr_cap !== 32'h0000_4040) begin errors++; $display("FAIL rstmid_refill_addr: got %h want 00004040", addr_cap); end
    checks++;
    if (i_rdata !== {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101}) begin
      errors++; $display("FAIL rstmid_refill_data: got %h", i_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    i_read  = 1'b0;
    i_addr  = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      tbl[k]  = '0;
      wcap[k] = '0;
    end
    addr_cap = '0;
    test_reset;
    test_icache_fill;
    test_dcache_writeback;
    test_contention;
    test_back_to_back;
    test_stalled;
    test_reset_mid_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
